// File: rtl/nv_ram_pkg.sv
// nv_ram_pkg: shared definitions for the parametrised 1R1W RAM model.
//   - clr_state_e  : clear-sequencer state encoding (CLEAR=0, READY=1)
//   - clog2        : constant function for deriving address widths
//   - lane_merge   : bitwise merge of old/new words under an expanded
//                    per-bit mask, shared by the write path and the
//                    optional bypass path so both always agree.
// Optional feature macro used by the top: NV_RAM_RWS_PARAM_BYPASS_EN.
package nv_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // lane_merge works on a fixed-width container; callers size-cast their
  // words in and the result back out, so WIDTH must not exceed this.
  localparam int MERGE_MAX_W = 4096;

  // Smallest n with 2**n >= value (value >= 2).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Bits with bit_mask=1 take new_w, the rest keep old_w.
  function automatic logic [MERGE_MAX_W-1:0] lane_merge(
    input logic [MERGE_MAX_W-1:0] old_w,
    input logic [MERGE_MAX_W-1:0] new_w,
    input logic [MERGE_MAX_W-1:0] bit_mask
  );
    return (old_w & ~bit_mask) | (new_w & bit_mask);
  endfunction

endpackage

// File: rtl/nv_ram_rws_param_clr.sv
// nv_ram_rws_param_clr: post-reset clear sequencer.
// After reset it walks addresses 0..DEPTH-1, one per cycle, requesting a
// zero write to each, then parks in READY until the next reset.
// Ports:
//   clk        core clock
//   reset_     asynchronous active-low reset
//   clr_we     request to write zero at clr_addr this cycle
//   clr_addr   address being cleared
//   init_busy  high while the sweep is in progress
//   clr_state  current FSM state (debug visibility and ready decode)
module nv_ram_rws_param_clr
  import nv_ram_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_busy,
  output clr_state_e    clr_state
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= CLEAR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        // The write of the last address happens on the same edge that
        // moves us to READY, so the sweep is exactly DEPTH cycles.
        if (addr_q == LAST_ADDR) state_d = READY;
        else                     addr_d  = addr_q + 1'b1;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign clr_addr  = addr_q;
  assign init_busy = (state_q == CLEAR);
  assign clr_state = state_q;

endmodule

// File: rtl/nv_ram_rws_param.sv
// nv_ram_rws_param: parametrised 1R1W synchronous-read RAM model with
// lane write masking, registered read data plus valid strobe, optional
// extra output stage (RD_PIPE=1) and a post-reset hardware clear.
// Ports:
//   clk            core clock
//   reset_         asynchronous active-low reset
//   ra, re         read address / read enable
//   dout, dout_vld registered read data and one-cycle valid strobe
//   wa, we, di     write address / enable / data
//   wmask          per-lane write enable, lane i = di[i*MASK_W +: MASK_W]
//   pwrbus_ram_pd  power-down bus, kept for interface compatibility only
//   init_busy      high while the clear runs; re/we are ignored then
// Handshake: no back-pressure. A read is accepted on any edge where re=1
// and the array is ready; dout_vld pulses exactly once per accepted read,
// 1 cycle later (RD_PIPE=0) or 2 cycles later (RD_PIPE=1). dout holds its
// value between accepted reads.
// Collision (same-cycle read and write of one address) is read-before-write
// unless NV_RAM_RWS_PARAM_BYPASS_EN is defined, in which case the read
// returns the lane-merged write data.
module nv_ram_rws_param
  import nv_ram_pkg::*;
#(
  parameter  int DEPTH   = 32,
  parameter  int WIDTH   = 768,
  parameter  int MASK_W  = 8,
  parameter  int RD_PIPE = 0,
  localparam int AW      = clog2(DEPTH),
  localparam int LANES   = WIDTH / MASK_W
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic [LANES-1:0] wmask,
  input  logic [31:0]      pwrbus_ram_pd,
  output logic             init_busy
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  clr_state_e       clr_state;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             ready;
  logic             ra_ok, wa_ok;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] wmask_bits;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd1_q;
  logic             vld1_q;
  logic             unused_pwrbus;

  assign unused_pwrbus = ^pwrbus_ram_pd;

  nv_ram_rws_param_clr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr (
    .clk       (clk),
    .reset_    (reset_),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy),
    .clr_state (clr_state)
  );

  assign ready = (clr_state == READY);
  // DEPTH need not be a power of two, so the top address codes are holes.
  assign ra_ok = ({1'b0, ra} < DEPTH_C);
  assign wa_ok = ({1'b0, wa} < DEPTH_C);
  assign wr_en = ready & we & wa_ok;
  assign rd_en = ready & re;

  always_comb begin
    wmask_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      wmask_bits[i*MASK_W +: MASK_W] = {MASK_W{wmask[i]}};
    end
  end

  assign wr_word = WIDTH'(lane_merge(MERGE_MAX_W'(mem[wa]),
                                     MERGE_MAX_W'(di),
                                     MERGE_MAX_W'(wmask_bits)));

  // Array: no reset; the clear sequencer zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (clr_we)     mem[clr_addr] <= '0;
    else if (wr_en) mem[wa]       <= wr_word;
  end

  always_comb begin
    rd_word = '0;
    if (ra_ok) begin
      rd_word = mem[ra];
`ifdef NV_RAM_RWS_PARAM_BYPASS_EN
      // Write-through ahead of the output stages, so latency is unchanged.
      if (wr_en && (wa == ra)) rd_word = wr_word;
`endif
    end
  end

  // First output stage: only updates on an accepted read, so later writes
  // to the same address never disturb the held value.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd1_q  <= '0;
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= rd_en;
      if (rd_en) rd1_q <= rd_word;
    end
  end

  if (RD_PIPE == 1) begin : g_pipe
    logic [WIDTH-1:0] rd2_q;
    logic             vld2_q;

    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        rd2_q  <= '0;
        vld2_q <= 1'b0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) rd2_q <= rd1_q;
      end
    end

    assign dout     = rd2_q;
    assign dout_vld = vld2_q;
  end else begin : g_nopipe
    assign dout     = rd1_q;
    assign dout_vld = vld1_q;
  end

endmodule
